// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared types for the pipeline stage register.
//   state_e : occupancy state of the two-entry (SKID=1) variant.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle around one pipeline stage.
//   in_*  : upstream side (in_valid/in_data toward the stage, in_ready back)
//   out_* : downstream side (out_valid/out_data from the stage, out_ready back)
//   master : environment driving the stage; slave : the stage itself.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: single payload register with load and control-bit clear.
//   i_clk, i_rst  : clock, synchronous active-high reset (clears to 0)
//   i_load, i_d   : capture i_d
//   i_clr_ctrl    : zero the CTRL_WIDTH low bits; wins over i_load
//   o_q           : held payload
module pipe_skid_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clr_ctrl,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Shifting all-ones right by WIDTH yields zero, so CTRL_WIDTH=0 gives an empty mask.
  localparam logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b1}} >> (WIDTH - CTRL_WIDTH);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)           r_q <= '0;
    else if (i_clr_ctrl) r_q <= r_q & ~CTRL_MASK;
    else if (i_load)     r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register with valid/ready handshake.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   io_bus (slave)   : in_valid/in_ready/in_data, out_valid/out_ready/out_data
//   i_flush          : drop all held entries, zero their control bits
//   i_stall_cnt_clr  : clear stall counter
//   o_stall_cnt      : saturating count of out_valid && !out_ready cycles
// SKID=1 gives a two-entry buffer with registered in_ready; SKID=0 a single
// entry whose in_ready depends combinationally on out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 6,
  parameter bit SKID       = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pipe_stage_reg_if.slave      io_bus,
  input  logic                 i_flush,
  input  logic                 i_stall_cnt_clr,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic             w_accept;
  logic             w_deliver;

  assign w_accept  = io_bus.in_valid && w_in_ready;
  assign w_deliver = w_out_valid && io_bus.out_ready;

  generate
    if (SKID) begin : g_skid
      state_e           r_state;
      state_e           w_state_nxt;
      logic             r_in_ready;
      logic             r_out_valid;
      logic             w_main_ld;
      logic             w_skid_ld;
      logic [WIDTH-1:0] w_main_d;
      logic [WIDTH-1:0] w_main_q;
      logic [WIDTH-1:0] w_skid_q;

      // Flush forces EMPTY and suppresses every slot load, so a same-cycle
      // accept never lands anywhere.
      always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_skid_ld   = 1'b0;
        w_main_d    = io_bus.in_data;
        if (i_flush) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              w_main_ld = w_accept;
              if (w_accept) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
              w_main_ld = w_accept && w_deliver;
              w_skid_ld = w_accept && !w_deliver;
              if (w_accept && !w_deliver)      w_state_nxt = ST_SKID;
              else if (!w_accept && w_deliver) w_state_nxt = ST_EMPTY;
            end
            ST_SKID: begin
              // Older entry leaves; the skid entry becomes the head.
              w_main_ld = w_deliver;
              w_main_d  = w_skid_q;
              if (w_deliver) w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
          endcase
        end
      end

      // Handshake outputs are registered from the next state, which keeps
      // out_ready off any combinational path to in_ready.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end else begin
          r_state     <= w_state_nxt;
          r_in_ready  <= (w_state_nxt != ST_SKID);
          r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
      end

      pipe_skid_slot #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_main_ld), .i_clr_ctrl(i_flush),
        .i_d(w_main_d), .o_q(w_main_q)
      );

      pipe_skid_slot #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_skid_ld), .i_clr_ctrl(i_flush),
        .i_d(io_bus.in_data), .o_q(w_skid_q)
      );

      assign w_in_ready  = r_in_ready;
      assign w_out_valid = r_out_valid;
      assign w_out_data  = w_main_q;
    end else begin : g_single
      logic r_out_valid;

      always_ff @(posedge i_clk) begin
        if (i_rst)          r_out_valid <= 1'b0;
        else if (i_flush)   r_out_valid <= 1'b0;
        else if (w_accept)  r_out_valid <= 1'b1;
        else if (w_deliver) r_out_valid <= 1'b0;
      end

      pipe_skid_slot #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_accept && !i_flush),
        .i_clr_ctrl(i_flush), .i_d(io_bus.in_data), .o_q(w_out_data)
      );

      assign w_in_ready  = io_bus.out_ready || !r_out_valid;
      assign w_out_valid = r_out_valid;
    end
  endgenerate

  // Stall counter: clear wins over increment, holds at all-ones.
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_stall_cnt_clr)
      r_stall_cnt <= '0;
    else if (w_out_valid && !io_bus.out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_data  = w_out_data;
  assign o_stall_cnt      = r_stall_cnt;

endmodule
